// File: rtl/morgan_resp_checker.sv
// morgan_resp_checker
//   Receiving end of the exhaustive 6-input De Morgan sweep. It samples each
//   applied vector with the DUT outputs Z/G/H and compares them against the
//   golden functions. It counts errors, records the first failing vector,
//   tracks vector coverage and reports a pass/done verdict.
//
//   Optional build macro: MORGAN_CHK_HALT_EN. When defined, the first
//   mismatch ends the run.
//
// Ports
//   clk, rstn         : clock (rising edge), async active-low reset
//   start             : one-cycle pulse that clears results and (re)arms a run
//   vec_valid, vec    : sample strobe and applied stimulus {a,b,c,d,e,f}
//   z, g, h           : DUT outputs sampled with vec
//   busy, done, pass  : run status; pass is meaningful while done=1
//   err_cnt, smp_cnt  : mismatching samples (saturating) / accepted samples
//   first_fail        : vector of the first mismatch (0 if none)
//   fail_seen         : at least one mismatch this run
//   cov_full          : vec values 0..N_VECTORS-1 have all been seen
module morgan_resp_checker #(
  parameter int N_VECTORS = 64,
  parameter int CNT_W     = 7
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             vec_valid,
  input  logic [5:0]       vec,
  input  logic             z,
  input  logic             g,
  input  logic             h,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] smp_cnt,
  output logic [5:0]       first_fail,
  output logic             fail_seen,
  output logic             cov_full
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [63:0]      bitmap_q, bitmap_d;
  logic             exp_zg, mismatch, accept, last, finish, halt_hit;
  logic [CNT_W-1:0] err_d;

  // Z and G are both NAND of all six inputs; H must report Z==G.
  assign exp_zg   = ~&vec;
  assign mismatch = ({z, g, h} != {exp_zg, exp_zg, 1'b1});

  // start takes priority: a sample arriving with start is dropped.
  assign accept   = (state_q == RUN) & vec_valid & ~start;
  assign last     = (smp_cnt == CNT_W'(N_VECTORS - 1));

`ifdef MORGAN_CHK_HALT_EN
  assign halt_hit = mismatch;
`else
  assign halt_hit = 1'b0;
`endif

  assign finish   = accept & (last | halt_hit);

  always_comb begin
    err_d = err_cnt;
    if (mismatch && (err_cnt != {CNT_W{1'b1}}))
      err_d = err_cnt + 1'b1;
  end

  // Out-of-range vectors are checked and counted but never set coverage.
  always_comb begin
    bitmap_d = bitmap_q;
    if ({1'b0, vec} < 7'(N_VECTORS))
      bitmap_d[vec] = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start)
      state_d = RUN;
    else if (finish)
      state_d = DONE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bitmap_q   <= '0;
      err_cnt    <= '0;
      smp_cnt    <= '0;
      first_fail <= '0;
      fail_seen  <= 1'b0;
      pass       <= 1'b0;
    end else if (start) begin
      bitmap_q   <= '0;
      err_cnt    <= '0;
      smp_cnt    <= '0;
      first_fail <= '0;
      fail_seen  <= 1'b0;
      pass       <= 1'b0;
    end else if (accept) begin
      bitmap_q <= bitmap_d;
      smp_cnt  <= smp_cnt + 1'b1;
      if (mismatch) begin
        err_cnt <= err_d;
        if (!fail_seen) begin
          first_fail <= vec;
          fail_seen  <= 1'b1;
        end
      end
      // Verdict uses post-sample values so the final sample is included.
      if (finish)
        pass <= (err_d == '0) & (&bitmap_d[N_VECTORS-1:0]);
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign cov_full = &bitmap_q[N_VECTORS-1:0];

endmodule

// File: tb/tb_morgan_resp_checker.sv
module tb_morgan_resp_checker;
  localparam int N     = 64;
  localparam int CNT_W = 7;

  logic             clk = 1'b0;
  logic             rstn, start, vec_valid, z, g, h;
  logic [5:0]       vec;
  logic             busy, done, pass, fail_seen, cov_full;
  logic [CNT_W-1:0] err_cnt, smp_cnt;
  logic [5:0]       first_fail;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit m_run, m_done, m_pass, m_fs;
  int m_smp, m_err, m_ff;
  bit seen [N];

  morgan_resp_checker #(.N_VECTORS(N), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn), .start(start), .vec_valid(vec_valid), .vec(vec),
    .z(z), .g(g), .h(h), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .smp_cnt(smp_cnt), .first_fail(first_fail),
    .fail_seen(fail_seen), .cov_full(cov_full)
  );

  always #5 clk = ~clk;

  function automatic bit m_cov();
    for (int i = 0; i < N; i++) if (!seen[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic m_clear();
    m_smp = 0; m_err = 0; m_ff = 0; m_fs = 0; m_pass = 0; m_done = 0;
    for (int i = 0; i < N; i++) seen[i] = 0;
  endtask

  task automatic m_reset();
    m_clear();
    m_run = 0;
  endtask

  task automatic model(input bit st, input bit v, input int vv, input logic [2:0] zgh);
    bit bad;
    bit golden;
    if (st) begin
      m_clear();
      m_run = 1;
    end else if (m_run && v) begin
      golden = (vv != 63);  // NAND of six bits is 0 only for all-ones
      bad = (zgh !== {golden, golden, 1'b1});
      m_smp++;
      if (vv < N) seen[vv] = 1;
      if (bad) begin
        if (m_err < (1 << CNT_W) - 1) m_err++;
        if (!m_fs) begin m_ff = vv; m_fs = 1; end
      end
`ifdef MORGAN_CHK_HALT_EN
      if (m_smp == N || bad) begin
`else
      if (m_smp == N) begin
`endif
        m_run = 0; m_done = 1;
        m_pass = (m_err == 0) && m_cov();
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".busy"},       32'(busy),       32'(m_run));
    chk({tag, ".done"},       32'(done),       32'(m_done));
    chk({tag, ".pass"},       32'(pass),       32'(m_pass));
    chk({tag, ".err_cnt"},    32'(err_cnt),    32'(m_err));
    chk({tag, ".smp_cnt"},    32'(smp_cnt),    32'(m_smp));
    chk({tag, ".first_fail"}, 32'(first_fail), 32'(m_ff));
    chk({tag, ".fail_seen"},  32'(fail_seen),  32'(m_fs));
    chk({tag, ".cov_full"},   32'(cov_full),   32'(m_cov()));
  endtask

  // one cycle: drive at negedge, model + check 1 time unit after posedge
  task automatic step(input string tag, input bit st, input bit v, input int vv,
                      input logic [2:0] flip);
    logic [5:0] v6;
    logic       gz;
    v6 = 6'(vv);
    gz = ~&v6;
    @(negedge clk);
    start = st; vec_valid = v; vec = v6;
    {z, g, h} = {gz, gz, 1'b1} ^ flip;
    @(posedge clk);
    model(st, v, vv, {z, g, h});
    #1 check_all(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 0, 0, 3'b000);
  endtask

  initial begin
    int perm [N];
    int j, t;
    rstn = 1'b0; start = 0; vec_valid = 0; vec = '0; z = 0; g = 0; h = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1 check_all("reset");
    @(negedge clk) rstn = 1'b1;

    // golden sweep
    step("gold_start", 1, 0, 0, 3'b000);
    for (int v = 0; v < N; v++) step("gold", 0, 1, v, 3'b000);
    chk("gold_done", 32'(done), 1);
    chk("gold_pass", 32'(pass), 1);
    chk("gold_smp",  32'(smp_cnt), 64);
    idle("gold_hold");

    // injected faults: z forced 1 at 63, h=0 at 5
    step("flt_start", 1, 0, 0, 3'b000);
    for (int v = 0; v < N; v++)
      step("flt", 0, 1, v, (v == 63) ? 3'b100 : (v == 5) ? 3'b001 : 3'b000);
    chk("flt_done", 32'(done), 1);
    chk("flt_pass", 32'(pass), 0);
    chk("flt_ff",   32'(first_fail), 5);
`ifdef MORGAN_CHK_HALT_EN
    chk("flt_err",  32'(err_cnt), 1);
    chk("flt_smp",  32'(smp_cnt), 6);
`else
    chk("flt_err",  32'(err_cnt), 2);
`endif

    // coverage hole: 12 twice, 13 never
    step("hole_start", 1, 0, 0, 3'b000);
    for (int v = 0; v < N; v++) step("hole", 0, 1, (v == 13) ? 12 : v, 3'b000);
    chk("hole_cov",  32'(cov_full), 0);
    chk("hole_pass", 32'(pass), 0);
    chk("hole_done", 32'(done), 1);

    // gapped valid with a pre-start sample
    step("gap_pre", 0, 1, 7, 3'b100);
    step("gap_start", 1, 0, 0, 3'b000);
    for (int v = 0; v < N; v++) begin
      step("gap", 0, 1, v, 3'b000);
      step("gap_hole", 0, 0, 63 - v, 3'b010);
    end
    chk("gap_pass", 32'(pass), 1);

    // reset mid-run
    step("rst_start", 1, 0, 0, 3'b000);
    for (int v = 0; v < 20; v++) step("rst_pre", 0, 1, v, 3'b000);
    @(negedge clk) rstn = 1'b0;
    m_reset();
    #1 check_all("rst_async");
    @(negedge clk) rstn = 1'b1;
    step("rst_start2", 1, 0, 0, 3'b000);
    for (int v = 0; v < N; v++) step("rst_sweep", 0, 1, v, 3'b000);
    chk("rst_pass", 32'(pass), 1);

    // restart collision: start with a valid faulty sample mid-run
    step("col_start", 1, 0, 0, 3'b000);
    for (int v = 0; v < 10; v++) step("col_pre", 0, 1, v, (v == 3) ? 3'b010 : 3'b000);
    step("col", 1, 1, 40, 3'b111);
    chk("col_smp", 32'(smp_cnt), 0);
    chk("col_err", 32'(err_cnt), 0);

    // randomized: shuffled full sweep
    for (int i = 0; i < N; i++) perm[i] = i;
    for (int i = N - 1; i > 0; i--) begin
      j = $urandom_range(i, 0);
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    step("perm_start", 1, 0, 0, 3'b000);
    for (int i = 0; i < N; i++) begin
      if ($urandom_range(3, 0) == 0) step("perm_gap", 0, 0, i, 3'b000);
      step("perm", 0, 1, perm[i], 3'b000);
    end
    chk("perm_pass", 32'(pass), 1);

    // randomized: random vectors, faults, gaps and restarts
    step("rnd_start", 1, 0, 0, 3'b000);
    for (int i = 0; i < 400; i++)
      step("rnd", ($urandom_range(149, 0) == 0), ($urandom_range(3, 0) != 0),
           $urandom_range(63, 0),
           ($urandom_range(15, 0) == 0) ? 3'($urandom_range(7, 1)) : 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/morgan_resp_checker.md
Name: morgan_resp_checker

Overview:
- Hardware response checker for the 6-input De Morgan block: the receiving, checking end of the exhaustive 64-vector stimulus sweep.
- Samples each applied vector together with the DUT outputs Z/G/H and compares them against the golden De Morgan functions.
- Counts errors, records the first failing vector, tracks vector coverage and reports a single pass/done verdict.
- Sits beside the DUT on board or in simulation, fed by any 6-bit stimulus generator.

Parameters:
- N_VECTORS, 64, number of accepted samples that completes a run; legal range 1..64.
- CNT_W, 7, width of the sample and error counters; must hold N_VECTORS.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; clears results and arms a run.
- vec_valid  in  1  vec/z/g/h are valid this cycle.
- vec  in  6  applied stimulus {a,b,c,d,e,f}, a = vec[5].
- z  in  1  DUT output Z.
- g  in  1  DUT output G.
- h  in  1  DUT output H.
- busy  out  1  run in progress (state RUN).
- done  out  1  run finished; held until the next start.
- pass  out  1  valid when done; 1 = zero errors and full coverage.
- err_cnt  out  CNT_W  mismatching samples, saturating at all-ones.
- smp_cnt  out  CNT_W  accepted samples.
- first_fail  out  6  vector of the first mismatch; 0 if none.
- fail_seen  out  1  at least one mismatch this run.
- cov_full  out  1  every value 0..N_VECTORS-1 of vec has been seen.

Behaviour:
- Reset (rstn=0, async): state IDLE; busy, done, pass, fail_seen, cov_full = 0; err_cnt, smp_cnt, first_fail = 0; coverage bitmap cleared.
- Golden functions, combinational from vec:
  - expZ = ~(a&b&c&d&e&f)
  - expG = ~a|~b|~c|~d|~e|~f
  - expH = 1 (Z equals G)
- A sample mismatches when {z,g,h} != {expZ,expG,expH}.
- IDLE: vec_valid is ignored. start moves to RUN next cycle and clears all counters, first_fail, fail_seen, the bitmap, done and pass.
- RUN: busy=1. Each cycle with vec_valid=1:
  - smp_cnt increments.
  - The bitmap bit [vec] is set.
  - On a mismatch, err_cnt increments (saturating).
  - On the first mismatch, first_fail is loaded with vec and fail_seen is set.
  - All outputs are registered, so results are visible one cycle after the sample.
- RUN to DONE in the cycle the N_VECTORS-th sample is accepted; that sample is counted. Samples after it are ignored.
- DONE: busy=0, done=1, and pass = (err_cnt==0) & cov_full, both registered on DONE entry. Outputs hold until start.
- Coverage:
  - cov_full = bits [N_VECTORS-1:0] of the bitmap are all set.
  - A vec >= N_VECTORS is checked and counted but does not set coverage.
  - A repeated vector counts as a sample but adds no coverage, so pass=0 if coverage is missing at completion.
- start while in RUN or DONE restarts the run, with the same clear action as from IDLE. start and vec_valid in the same cycle: start wins and the sample is dropped.
- rstn asserted mid-run aborts immediately to the reset values above.

Optional Feature:
- Macro: MORGAN_CHK_HALT_EN.
- Defined: the first mismatch ends the run. RUN goes to DONE in that cycle with pass=0; err_cnt=1, first_fail = the failing vector, and smp_cnt includes the failing sample.
- Undefined: the run always continues for the full N_VECTORS samples as described above.

Test Plan:
- Golden sweep: reset, start, vec 0..63 one per cycle with correct z/g/h -> after the 64th sample done=1, pass=1, err_cnt=0, smp_cnt=64, cov_full=1, first_fail=0.
- Injected faults: same sweep with z forced 1 at vec=63 and h=0 at vec=5 -> done=1, pass=0, err_cnt=2, first_fail=6'd5, fail_seen=1. With MORGAN_CHK_HALT_EN: done one cycle after vec=5, smp_cnt=6, err_cnt=1.
- Coverage hole: 64 correct samples with vec=12 sent twice and vec=13 never -> err_cnt=0, cov_full=0, pass=0.
- Gapped valid: vec_valid low every other cycle, plus a sample sent before start -> the pre-start sample is ignored, smp_cnt=64 at done, result identical to the golden sweep.
- Reset mid-run: rstn low for 1 cycle after 20 samples -> all outputs 0 asynchronously; a fresh start and full sweep then gives pass=1.
- Restart and collision: start asserted in the same cycle as a valid sample during RUN -> counters cleared, the sample is dropped, and smp_cnt=0 on the next cycle.
